// File: rtl/sync_bus_qualifier.sv
// sync_bus_qualifier
// Sits right after a multibit synchronizer flop. A sampled bus value is
// published on o_data only once it has been seen unchanged for
// STABLE_CYCLES consecutive edges, so mixed-bit transients never leak
// downstream. o_valid pulses for one cycle when a genuinely new value is
// published; o_locked stays high while the input matches the published value.
//
// Optional feature macro: STABLE_REJECT_CNT_EN
//   When defined, adds o_reject_count, a saturating count of candidates that
//   were abandoned before reaching the stability threshold. When undefined,
//   the port and its counter are absent and all other behaviour is unchanged.

module sync_bus_qualifier #(
    parameter int NB            = 8,
    parameter int STABLE_CYCLES = 3,
    parameter int CNT_NB        = 8
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [NB-1:0]     i_data,
    output logic [NB-1:0]     o_data,
    output logic              o_valid,
    output logic              o_locked
`ifdef STABLE_REJECT_CNT_EN
    ,
    output logic [CNT_NB-1:0] o_reject_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Count value at which the next matching sample is the final one needed.
    localparam logic [3:0] COMMIT_CNT = 4'(STABLE_CYCLES - 1);

    // Reject parameter combinations the 4-bit sample counter cannot serve.
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 15 || CNT_NB < 1) begin : g_param_check
        $error("sync_bus_qualifier: STABLE_CYCLES must be 2..15 and CNT_NB >= 1");
    end

    state_t          state_reg, state_next;
    logic [NB-1:0]   cand_reg,  cand_next;
    logic [3:0]      cnt_reg,   cnt_next;
    logic            first_reg, first_next;
    logic [NB-1:0]   data_reg,  data_next;
    logic            valid_reg, valid_next;
    logic            locked_reg, locked_next;

    logic [NB-1:0]   diff_bits;
    logic            cand_match;

    // Per-bit difference between the incoming sample and the current candidate.
    for (genvar gi = 0; gi < NB; gi++) begin : g_diff
        assign diff_bits[gi] = i_data[gi] ^ cand_reg[gi];
    end
    assign cand_match = ~|diff_bits;

    // Next-state and next-output decode for the qualification FSM.
    always_comb begin
        state_next = state_reg;
        cand_next  = cand_reg;
        cnt_next   = cnt_reg;
        first_next = first_reg;
        data_next  = data_reg;
        valid_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // First edge out of reset: whatever is on the bus becomes the candidate.
                cand_next  = i_data;
                cnt_next   = 4'd1;
                state_next = ST_TRACK;
            end
            ST_TRACK: begin
                if (!cand_match) begin
                    // Candidate abandoned before it settled; restart on the new sample.
                    cand_next = i_data;
                    cnt_next  = 4'd1;
                end else if (cnt_reg == COMMIT_CNT) begin
                    // Enough identical samples: publish. Re-committing the same
                    // value after a glitch is silent unless nothing was published yet.
                    data_next  = cand_reg;
                    valid_next = first_reg || (cand_reg != data_reg);
                    first_next = 1'b0;
                    state_next = ST_LOCKED;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            ST_LOCKED: begin
                if (!cand_match) begin
                    // Leaving a committed value is not a reject.
                    cand_next  = i_data;
                    cnt_next   = 4'd1;
                    state_next = ST_TRACK;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        locked_next = (state_next == ST_LOCKED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg  <= ST_IDLE;
            cand_reg   <= '0;
            cnt_reg    <= 4'd0;
            first_reg  <= 1'b1;
            data_reg   <= '0;
            valid_reg  <= 1'b0;
            locked_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cand_reg   <= cand_next;
            cnt_reg    <= cnt_next;
            first_reg  <= first_next;
            data_reg   <= data_next;
            valid_reg  <= valid_next;
            locked_reg <= locked_next;
        end
    end

    assign o_data   = data_reg;
    assign o_valid  = valid_reg;
    assign o_locked = locked_reg;

`ifdef STABLE_REJECT_CNT_EN
    logic [CNT_NB-1:0] reject_reg;
    logic              reject_inc;

    // Only a mismatch while still tracking abandons a candidate.
    assign reject_inc = (state_reg == ST_TRACK) && !cand_match;

    // Saturating reject counter, cleared only by reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            reject_reg <= '0;
        end else if (reject_inc && (reject_reg != {CNT_NB{1'b1}})) begin
            reject_reg <= reject_reg + 1'b1;
        end
    end

    assign o_reject_count = reject_reg;
`endif

endmodule

// File: doc/sync_bus_qualifier.md
# sync_bus_qualifier

- Single-clock stage directly downstream of the multibit synchronizer flop.
- Consumes the raw bus sampled in the destination clock domain. That bus can show transient mixed-bit values while the source changes.
- Publishes a value only after it has been identical for STABLE_CYCLES consecutive clock edges, and flags each genuinely new value with a one-cycle o_valid pulse.

## Interface

Parameters:
- NB, 8, data bus width.
- STABLE_CYCLES, 3, consecutive identical samples required to commit; legal range 2..15.
- CNT_NB, 8, width of the reject counter (used only with STABLE_REJECT_CNT_EN).

Ports:
- i_clock  input  1  destination-domain clock; all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_data  input  NB  synchronizer output, not yet qualified.
- o_data  output  NB  last committed stable value; reset 0.
- o_valid  output  1  one-cycle pulse when o_data takes a new value; reset 0.
- o_locked  output  1  high while i_data matches the committed value; reset 0.
- o_reject_count  output  CNT_NB  saturating count of abandoned candidates; reset 0; present only with STABLE_REJECT_CNT_EN.

## Operation

Internal state:
- r_cand (NB): candidate value.
- r_cnt (4 bits): number of consecutive samples matching r_cand.
- r_first: set by reset, cleared on the first commit.
- FSM: IDLE, TRACK, LOCKED.

Transitions:
- IDLE (reset state): at the next edge, r_cand<=i_data, r_cnt<=1, go to TRACK.
- TRACK, when i_data != r_cand:
  - Reload r_cand<=i_data and r_cnt<=1.
  - Stay in TRACK.
  - Count one reject.
- TRACK, when i_data == r_cand and r_cnt == STABLE_CYCLES-1:
  - o_data<=r_cand, then go to LOCKED.
  - o_valid<=1 only if r_first==1 or r_cand != o_data.
  - Clear r_first.
- TRACK, any other match: r_cnt<=r_cnt+1.
- LOCKED, when i_data != r_cand: r_cand<=i_data, r_cnt<=1, go to TRACK. No reject is counted.
- LOCKED, when i_data == r_cand: hold.

Outputs:
- o_locked = (state==LOCKED); registered.
- o_data changes only on a commit. It never shows a value seen for fewer than STABLE_CYCLES samples.
- A glitch that returns to the committed value (A→B→A):
  - Counts one reject when B is abandoned.
  - Recommits A with o_valid=0.

## Timing

- V first sampled at edge k and held through edge k+STABLE_CYCLES-1 (STABLE_CYCLES samples):
  - o_data=V and o_valid=1 are visible after edge k+STABLE_CYCLES-1.
  - o_valid returns to 0 after the following edge.
- Latency from the first sample of a new value to commit is STABLE_CYCLES-1 edges. o_valid is never high for two consecutive cycles.
- A change in i_data on the commit edge itself:
  - Cancels the commit.
  - The new value becomes the candidate with r_cnt=1.
- While i_reset=1 at an edge, all registers return to their reset values and the FSM goes to IDLE; any in-progress candidate is discarded. The first edge with i_reset=0 executes IDLE.
- With a constant input held through reset release, the first commit occurs STABLE_CYCLES edges after the first IDLE edge (one edge for IDLE plus STABLE_CYCLES-1 tracking edges). It asserts o_valid even if the value is 0.

## Configuration

- STABLE_REJECT_CNT_EN defined:
  - o_reject_count exists.
  - It increments by 1 on every TRACK mismatch and saturates at 2^CNT_NB-1.
  - It is cleared only by i_reset.
- STABLE_REJECT_CNT_EN undefined: the port and counter are removed. All other behaviour is identical.

## Test plan

- Reset then constant input: i_reset for 2 cycles, i_data=8'h5A constant, STABLE_CYCLES=3.
  - o_data=8'h5A and o_valid=1 visible after the 3rd edge following reset release.
  - o_locked=1 from then on.
- Clean change: locked at 8'h5A, switch to 8'hC3 and hold.
  - o_locked drops after the first edge.
  - o_data=8'hC3 with a single o_valid pulse 2 edges later.
- Glitch rejection: locked at 8'h00, apply 8'hFF for 1 cycle, then 8'h00.
  - o_data never shows 8'hFF; no o_valid pulse.
  - o_reject_count increments by 1.
- Toggling input: i_data alternates 8'h01/8'h02 every cycle for 20 cycles.
  - No commit and o_valid stays 0.
  - o_reject_count=19.
- Reset mid-track: candidate 8'h33 at r_cnt=2, assert i_reset for 1 edge.
  - o_data=0, o_valid=0, o_locked=0, o_reject_count=0.
  - Re-qualification of 8'h33 takes the full 3 samples.
- Counter saturation (CNT_NB=4): 40 rejects → o_reject_count holds at 15.
